pixel_fp_streamer: RTL



---
 rtl/gmm_pkg.sv | 17 +
 rtl/u8_to_fp32.sv | 25 ++
 rtl/pixel_fp_streamer.sv | 105 ++++++++++
 3 files changed

// File: rtl/gmm_pkg.sv
// rtl/gmm_pkg.sv - shared constants and sample type for the GMM datapath
package gmm_pkg;
   localparam int FP32_W      = 32;
   localparam int FP_EXP_BIAS = 127;
   localparam int PIX_W       = 8;
   localparam int SAMPLE_X_W  = 9;
   localparam int SAMPLE_Y_W  = 8;

   typedef struct packed {
      logic [FP32_W-1:0]     fp;
      logic [SAMPLE_X_W-1:0] x;
      logic [SAMPLE_Y_W-1:0] y;
      logic                  sof;
      logic                  eol;
      logic                  eof;
   } sample_t;
endpackage

// File: rtl/u8_to_fp32.sv
// rtl/u8_to_fp32.sv - exact combinational 8-bit unsigned to IEEE-754 single conversion
module u8_to_fp32
   import gmm_pkg::*;
(
   input  logic [PIX_W-1:0]  pixel,
   output logic [FP32_W-1:0] fp
);
   logic [2:0]  msb;
   logic [22:0] aligned;
   logic [22:0] frac;
   logic [7:0]  expo;

   always_comb begin
      msb = '0;
      for (int i = 0; i < PIX_W; i++) begin
         if (pixel[i]) msb = 3'(i);
      end
   end

   // shifting left by (8 - msb) pushes the implicit leading one out of the field
   assign aligned = {pixel, 15'd0};
   assign frac    = aligned << (4'd8 - {1'b0, msb});
   assign expo    = 8'(FP_EXP_BIAS) + {5'd0, msb};
   assign fp      = (pixel == '0) ? '0 : {1'b0, expo, frac};
endmodule

// File: rtl/pixel_fp_streamer.sv
// rtl/pixel_fp_streamer.sv - pixel to FP32 streamer with raster tags and output skid buffer
module pixel_fp_streamer
   import gmm_pkg::*;
#(
   parameter int IMG_W = 320,
   parameter int IMG_H = 240,
   parameter int X_W   = SAMPLE_X_W,
   parameter int Y_W   = SAMPLE_Y_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [PIX_W-1:0]  s_pixel,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [FP32_W-1:0] m_fp,
   output logic [X_W-1:0]    m_x,
   output logic [Y_W-1:0]    m_y,
   output logic              m_sof,
   output logic              m_eol,
   output logic              m_eof
);
   sample_t           out_q;
   sample_t           skid_q;
   sample_t           new_s;
   logic              out_valid;
   logic              skid_full;
   logic [X_W-1:0]    x_cnt;
   logic [Y_W-1:0]    y_cnt;
   logic              accept;
   logic              out_free;
   logic              last_x;
   logic              last_y;
   logic [FP32_W-1:0] pix_fp;

   u8_to_fp32 u_conv (
      .pixel (s_pixel),
      .fp    (pix_fp)
   );

   assign s_ready  = !skid_full;
   assign accept   = s_valid && s_ready && !restart;
   assign out_free = !out_valid || m_ready;
   assign last_x   = (x_cnt == X_W'(IMG_W - 1));
   assign last_y   = (y_cnt == Y_W'(IMG_H - 1));

   always_comb begin
      new_s.fp  = pix_fp;
      new_s.x   = SAMPLE_X_W'(x_cnt);
      new_s.y   = SAMPLE_Y_W'(y_cnt);
      new_s.sof = (x_cnt == '0) && (y_cnt == '0);
      new_s.eol = last_x;
      new_s.eof = last_x && last_y;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (restart) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (accept) begin
         x_cnt <= last_x ? '0 : x_cnt + 1'b1;
         if (last_x) y_cnt <= last_y ? '0 : y_cnt + 1'b1;
      end
   end

   // the skid only fills while the output is stalled, so it never coexists with an accept on drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         skid_full <= 1'b0;
         out_q     <= '0;
         skid_q    <= '0;
      end else if (restart) begin
         out_valid <= 1'b0;
         skid_full <= 1'b0;
      end else if (out_free) begin
         if (skid_full) begin
            out_q     <= skid_q;
            out_valid <= 1'b1;
            skid_full <= 1'b0;
         end else if (accept) begin
            out_q     <= new_s;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_q    <= new_s;
         skid_full <= 1'b1;
      end
   end

   assign m_valid = out_valid;
   assign m_fp    = out_q.fp;
   assign m_x     = X_W'(out_q.x);
   assign m_y     = Y_W'(out_q.y);
   assign m_sof   = out_q.sof;
   assign m_eol   = out_q.eol;
   assign m_eof   = out_q.eof;
endmodule
